mux_stream_nx1: RTL
===================

# mux_stream_nx1

Parametrised, registered N-to-1 stream multiplexer that carries the combinational `mux_2x1`/`mux_4x1`/`mux_8x1` family forward to multi-bit, handshaked datapaths. It selects one of `CHANNELS` valid/ready input streams of `WIDTH` bits, either by an explicit select or by round-robin arbitration, and presents the winner through a one-entry output register. It sits between multiple producers (e.g. fetch/LSU request ports) and a single shared consumer (e.g. a memory port).

## Interface
- `WIDTH`, 32: data bits per channel (≥1).
- `CHANNELS`, 4: number of input channels (≥2; need not be a power of two).
- `SEL_W`, localparam = max(1, clog2(CHANNELS)): select/channel-index width.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mode` in 1: 0 = fixed select by `sel`, 1 = round-robin.
- `sel` in SEL_W: channel index used when `mode`=0.
- `in_data` in CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in CHANNELS: per-channel valid.
- `in_ready` out CHANNELS: per-channel ready; at most one bit high.
- `out_data` out WIDTH: registered selected data.
- `out_chan` out SEL_W: index of the channel `out_data` came from.
- `out_valid` out 1: output register holds a beat.
- `out_ready` in 1: consumer accepts the beat.

## Operation
- Output register: one entry. `load_en = !out_valid || out_ready`.
- Grant (combinational, one-hot or zero):
  - mode 0: grant channel `sel` iff `sel < CHANNELS` and `in_valid[sel]`; out-of-range `sel` → no grant.
  - mode 1: first i with `in_valid[i]` scanning `ptr, ptr+1, …` modulo CHANNELS.
- `in_ready[i] = grant[i] && load_en`. Transfer on channel i when `in_valid[i] && in_ready[i]`.
- On transfer: `out_data ← in_data[i]`, `out_chan ← i`, `out_valid ← 1`.
- On `out_valid && out_ready` with no input transfer: `out_valid ← 0`; `out_data`/`out_chan` hold.
- Drain and load in the same cycle are allowed (full throughput).
- Round-robin pointer `ptr`: on a transfer in mode 1, `ptr ← (i+1)` wrapping from CHANNELS-1 to 0. Unchanged in mode 0 and on cycles without transfer.
- Changing `mode` or `sel` affects only the combinational grant of the current cycle. It never alters a beat already in the output register. `ptr` is preserved across mode changes.
- Inputs are not required to hold `in_valid` without `in_ready`. The block makes no fairness guarantee in mode 0.

## Timing
- Reset (`rst_n`=0 at a rising edge): `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0. `in_ready` is all-zero while `rst_n`=0, regardless of `load_en`. Reset overrides a simultaneous transfer, and a beat in flight is dropped.
- Latency: input transfer at edge N → `out_valid`=1 with that data after edge N, visible in cycle N+1.
- Throughput: one beat per cycle with `out_ready` held high.
- Stability: while `out_valid && !out_ready`, `out_data` and `out_chan` are stable and all `in_ready`=0.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `sel`, `ptr`. There is no combinational path from any input to `out_*`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1 and `out_ready`=1 → `out_valid`=0, `out_data`=0, `in_ready`=0 throughout. First beat appears in the cycle after the first edge with `rst_n`=1.
- Fixed select, CHANNELS=4, WIDTH=8, mode=0, sel=2, `in_data`={0x44,0x33,0x22,0x11}, all valid, `out_ready`=1 → `in_ready`=4'b0100 every cycle, `out_data`=0x33, `out_chan`=2 one cycle after first transfer. With sel=3 and `in_valid[3]`=0 → no grant, `out_valid` falls after drain.
- Round-robin fairness: mode=1, all four valid, `out_ready`=1 for 8 cycles → `out_chan` sequence 0,1,2,3,0,1,2,3. With only channels 1 and 3 valid → 1,3,1,3.
- Backpressure: mode=1, beat from ch0 loaded, `out_ready`=0 for 3 cycles → `out_data`/`out_chan` constant, `in_ready`=0, `ptr` stays 1. On `out_ready`=1, drain and ch1 load occur in the same cycle.
- Non-power-of-two: CHANNELS=3, mode=0, sel=3 → `in_ready`=0. Mode=1 with all valid → `out_chan` 0,1,2,0 (wrap from 2 to 0).
- Mode switch mid-stream: mode=1 after granting ch1 (`ptr`=2), switch to mode 0 with sel=0 for 2 beats, then back to mode 1 → next round-robin grant is ch2.

Source files
------------

// File: rtl/mux_stream_nx1.sv
// Registered N-to-1 valid/ready stream multiplexer with fixed-select or
// round-robin arbitration feeding a single one-entry output register.
module mux_stream_nx1 #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SEL_W-1:0] ptr;
   logic             load_en;
   logic             gnt_any;
   logic [SEL_W-1:0] gnt_idx;
   logic             xfer;
   logic [SEL_W-1:0] ptr_next;

   assign load_en = !out_valid || out_ready;

   always_comb begin : grant_logic
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (!mode) begin
         if (int'(sel) < CHANNELS && in_valid[sel]) begin
            gnt_any = 1'b1;
            gnt_idx = sel;
         end
      end else begin
         // Scan from the pointer, wrapping at CHANNELS (not at 2**SEL_W).
         for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!gnt_any && in_valid[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = SEL_W'(idx);
            end
         end
      end
   end

   // Reset masks ready so nothing is consumed from producers during reset.
   assign xfer     = rst_n && gnt_any && load_en;
   assign in_ready = xfer ? ({{(CHANNELS-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   assign ptr_next = (gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
         out_chan  <= gnt_idx;
         if (mode) ptr <= ptr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
